// File: rtl/control_unit_fsm.sv
// Instruction sequencer for the six-instruction processor: fetch, decode and execute control.
// Optional macro ILLEGAL_OP_HALT_EN: opcodes 6-15 stop the machine in HALT until reset.
module control_unit_fsm (
  input  logic        clk,
  input  logic        clr,
  output logic        imem_rd,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        pc_ld,
  output logic [15:0] pc_offset,
  output logic [15:0] ir,
  output logic [7:0]  d_addr,
  output logic        d_rd,
  output logic        d_wr,
  output logic [1:0]  rf_s,
  output logic [7:0]  rf_w_data,
  output logic [3:0]  rf_w_addr,
  output logic        rf_w_wr,
  output logic [3:0]  rf_rp_addr,
  output logic [3:0]  rf_rq_addr,
  output logic        rf_rp_rd,
  output logic        rf_rq_rd,
  output logic [1:0]  alu_s,
  input  logic        rf_rp_zero,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_LDC,
    S_JMPZ,
    S_JMPZ_TAKEN,
    S_NOP,
    S_HALT
  } state_t;

  typedef struct packed {
    logic        imem_rd;
    logic        pc_clr;
    logic        pc_up;
    logic        pc_ld;
    logic [15:0] pc_offset;
    logic [7:0]  d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [1:0]  rf_s;
    logic [7:0]  rf_w_data;
    logic [3:0]  rf_w_addr;
    logic        rf_w_wr;
    logic [3:0]  rf_rp_addr;
    logic [3:0]  rf_rq_addr;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic [1:0]  alu_s;
    logic        halted;
  } ctl_t;

  localparam logic [1:0] RF_SEL_ALU   = 2'b00;
  localparam logic [1:0] RF_SEL_DMEM  = 2'b01;
  localparam logic [1:0] RF_SEL_CONST = 2'b10;
  localparam logic [1:0] ALU_ADD      = 2'b01;
  localparam logic [1:0] ALU_SUB      = 2'b10;

  state_t      state;
  state_t      nxt_state;
  logic [15:0] nxt_ir;
  ctl_t        ctl;

  // Moore output table: the control word that belongs to a given state and instruction.
  function automatic ctl_t decode_ctl(input state_t s, input logic [15:0] i);
    ctl_t c;
    c = '0;
    c.pc_offset = {{8{i[7]}}, i[7:0]};
    case (s)
      S_INIT:       c.pc_clr = 1'b1;
      S_FETCH:      c.imem_rd = 1'b1;
      S_DECODE:     c.pc_up = 1'b1;
      S_LOAD: begin
        c.d_addr    = i[7:0];
        c.d_rd      = 1'b1;
        c.rf_s      = RF_SEL_DMEM;
        c.rf_w_addr = i[11:8];
        c.rf_w_wr   = 1'b1;
      end
      S_STORE: begin
        c.d_addr     = i[7:0];
        c.d_wr       = 1'b1;
        c.rf_rp_addr = i[11:8];
        c.rf_rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        c.rf_rp_addr = i[7:4];
        c.rf_rq_addr = i[3:0];
        c.rf_rp_rd   = 1'b1;
        c.rf_rq_rd   = 1'b1;
        c.alu_s      = (s == S_ADD) ? ALU_ADD : ALU_SUB;
        c.rf_s       = RF_SEL_ALU;
        c.rf_w_addr  = i[11:8];
        c.rf_w_wr    = 1'b1;
      end
      S_LDC: begin
        c.rf_s      = RF_SEL_CONST;
        c.rf_w_data = i[7:0];
        c.rf_w_addr = i[11:8];
        c.rf_w_wr   = 1'b1;
      end
      S_JMPZ: begin
        c.rf_rp_addr = i[11:8];
        c.rf_rp_rd   = 1'b1;
      end
      // PC already points one past the JMPZ, and PC_Module adds the offset to PC-1.
      S_JMPZ_TAKEN: c.pc_ld = 1'b1;
`ifdef ILLEGAL_OP_HALT_EN
      S_HALT: begin
        c           = '0;
        c.halted    = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_ir    = ir;
    case (state)
      S_INIT:  nxt_state = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          nxt_ir    = imem_data;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir[15:12])
          4'd0:    nxt_state = S_LOAD;
          4'd1:    nxt_state = S_STORE;
          4'd2:    nxt_state = S_ADD;
          4'd3:    nxt_state = S_LDC;
          4'd4:    nxt_state = S_SUB;
          4'd5:    nxt_state = S_JMPZ;
`ifdef ILLEGAL_OP_HALT_EN
          default: nxt_state = S_HALT;
`else
          default: nxt_state = S_NOP;
`endif
        endcase
      end
      S_JMPZ:  nxt_state = rf_rp_zero ? S_JMPZ_TAKEN : S_FETCH;
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they stay pure Moore functions of state and ir.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_INIT;
      ir    <= '0;
      ctl   <= decode_ctl(S_INIT, 16'h0000);
    end else begin
      state <= nxt_state;
      ir    <= nxt_ir;
      ctl   <= decode_ctl(nxt_state, nxt_ir);
    end
  end

  assign imem_rd    = ctl.imem_rd;
  assign pc_clr     = ctl.pc_clr;
  assign pc_up      = ctl.pc_up;
  assign pc_ld      = ctl.pc_ld;
  assign pc_offset  = ctl.pc_offset;
  assign d_addr     = ctl.d_addr;
  assign d_rd       = ctl.d_rd;
  assign d_wr       = ctl.d_wr;
  assign rf_s       = ctl.rf_s;
  assign rf_w_data  = ctl.rf_w_data;
  assign rf_w_addr  = ctl.rf_w_addr;
  assign rf_w_wr    = ctl.rf_w_wr;
  assign rf_rp_addr = ctl.rf_rp_addr;
  assign rf_rq_addr = ctl.rf_rq_addr;
  assign rf_rp_rd   = ctl.rf_rp_rd;
  assign rf_rq_rd   = ctl.rf_rq_rd;
  assign alu_s      = ctl.alu_s;
  assign halted     = ctl.halted;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed scenarios plus random instruction streams.
module tb_control_unit_fsm;

  logic        clk;
  logic        clr;
  logic        imem_rd;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        pc_clr, pc_up, pc_ld;
  logic [15:0] pc_offset;
  logic [15:0] ir;
  logic [7:0]  d_addr;
  logic        d_rd, d_wr;
  logic [1:0]  rf_s;
  logic [7:0]  rf_w_data;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_rp_addr, rf_rq_addr;
  logic        rf_rp_rd, rf_rq_rd;
  logic [1:0]  alu_s;
  logic        rf_rp_zero;
  logic        halted;

  int checks = 0;
  int errors = 0;

  control_unit_fsm dut (
    .clk(clk), .clr(clr), .imem_rd(imem_rd), .imem_valid(imem_valid), .imem_data(imem_data),
    .pc_clr(pc_clr), .pc_up(pc_up), .pc_ld(pc_ld), .pc_offset(pc_offset), .ir(ir),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .rf_s(rf_s), .rf_w_data(rf_w_data),
    .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr), .rf_rp_addr(rf_rp_addr), .rf_rq_addr(rf_rq_addr),
    .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd), .alu_s(alu_s), .rf_rp_zero(rf_rp_zero),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        imem_rd;
    logic        pc_clr;
    logic        pc_up;
    logic        pc_ld;
    logic [15:0] pc_offset;
    logic [15:0] ir;
    logic [7:0]  d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [1:0]  rf_s;
    logic [7:0]  rf_w_data;
    logic [3:0]  rf_w_addr;
    logic        rf_w_wr;
    logic [3:0]  rf_rp_addr;
    logic [3:0]  rf_rq_addr;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic [1:0]  alu_s;
    logic        halted;
  } sig_t;

  sig_t obs;
  always_comb begin
    obs = '0;
    obs.imem_rd = imem_rd;     obs.pc_clr = pc_clr;         obs.pc_up = pc_up;
    obs.pc_ld = pc_ld;         obs.pc_offset = pc_offset;   obs.ir = ir;
    obs.d_addr = d_addr;       obs.d_rd = d_rd;             obs.d_wr = d_wr;
    obs.rf_s = rf_s;           obs.rf_w_data = rf_w_data;   obs.rf_w_addr = rf_w_addr;
    obs.rf_w_wr = rf_w_wr;     obs.rf_rp_addr = rf_rp_addr; obs.rf_rq_addr = rf_rq_addr;
    obs.rf_rp_rd = rf_rp_rd;   obs.rf_rq_rd = rf_rq_rd;     obs.alu_s = alu_s;
    obs.halted = halted;
  end

  logic [15:0] cur_ir;

  // Idle outputs for a given instruction register: only ir and its sign-extended offset show.
  function automatic sig_t idle_exp(input logic [15:0] i);
    sig_t e;
    e = '0;
    e.ir = i;
    e.pc_offset = {{8{i[7]}}, i[7:0]};
    return e;
  endfunction

  // Execute-cycle expectations straight from the instruction table.
  function automatic sig_t exec_exp(input logic [15:0] i);
    sig_t e;
    int op;
    e = idle_exp(i);
    op = int'(i[15:12]);
    if (op == 0) begin
      e.d_addr = i[7:0]; e.d_rd = 1'b1; e.rf_s = 2'b01; e.rf_w_addr = i[11:8]; e.rf_w_wr = 1'b1;
    end else if (op == 1) begin
      e.d_addr = i[7:0]; e.d_wr = 1'b1; e.rf_rp_addr = i[11:8]; e.rf_rp_rd = 1'b1;
    end else if (op == 2 || op == 4) begin
      e.rf_rp_addr = i[7:4]; e.rf_rq_addr = i[3:0]; e.rf_rp_rd = 1'b1; e.rf_rq_rd = 1'b1;
      e.alu_s = (op == 2) ? 2'b01 : 2'b10; e.rf_s = 2'b00; e.rf_w_addr = i[11:8]; e.rf_w_wr = 1'b1;
    end else if (op == 3) begin
      e.rf_s = 2'b10; e.rf_w_data = i[7:0]; e.rf_w_addr = i[11:8]; e.rf_w_wr = 1'b1;
    end else if (op == 5) begin
      e.rf_rp_addr = i[11:8]; e.rf_rp_rd = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clr = 1'b1;
    imem_valid = 1'b0;
    step();
    step();
    clr = 1'b0;
    step();
    cur_ir = 16'h0000;
  endtask

  // One instruction transaction starting in FETCH; ends back in FETCH with every cycle compared.
  task automatic exec_instr(input string name, input logic [15:0] instr, input int waits,
                            input logic zero);
    sig_t e;
    for (int k = 0; k < waits; k++) begin
      imem_valid = 1'b0;
      imem_data  = 16'($urandom);
      step();
      e = idle_exp(cur_ir); e.imem_rd = 1'b1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s fetch_wait%0d: got %h expected %h", name, k, obs, e);
      end
    end
    imem_valid = 1'b1;
    imem_data  = instr;
    rf_rp_zero = zero;
    step();
    imem_valid = 1'b0;
    imem_data  = 16'($urandom);
    e = idle_exp(instr); e.pc_up = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s decode: got %h expected %h", name, obs, e);
    end
    step();
    e = exec_exp(instr);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s exec: got %h expected %h", name, obs, e);
    end
    if (instr[15:12] == 4'd5 && zero) begin
      step();
      e = idle_exp(instr); e.pc_ld = 1'b1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s jmpz_taken: got %h expected %h", name, obs, e);
      end
    end
    step();
    e = idle_exp(instr); e.imem_rd = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s refetch: got %h expected %h", name, obs, e);
    end
    cur_ir = instr;
  endtask

  task automatic test_reset();
    sig_t e;
    clr = 1'b1;
    imem_valid = 1'b0;
    imem_data = 16'h0000;
    rf_rp_zero = 1'b0;
    e = idle_exp(16'h0000); e.pc_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_hold%0d: got %h expected %h", k, obs, e);
      end
    end
    clr = 1'b0;
    #1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_first_cycle: got %h expected %h", obs, e);
    end
    step();
    e = idle_exp(16'h0000); e.imem_rd = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_second_cycle: got %h expected %h", obs, e);
    end
    cur_ir = 16'h0000;
  endtask

  task automatic test_ldc();
    exec_instr("ldc", 16'h3105, 0, 1'b0);
  endtask

  task automatic test_add_sub();
    exec_instr("add", 16'h2312, 0, 1'b1);
    exec_instr("sub", 16'h4312, 0, 1'b0);
    exec_instr("load", 16'h0A7C, 1, 1'b0);
    exec_instr("store", 16'h1B80, 2, 1'b1);
  endtask

  task automatic test_jmpz();
    exec_instr("jmpz_taken", 16'h52FD, 0, 1'b1);
    exec_instr("jmpz_not_taken", 16'h52FD, 0, 1'b0);
    exec_instr("jmpz_fwd", 16'h5F10, 1, 1'b1);
  endtask

  task automatic test_wait_and_reset();
    sig_t e;
    exec_instr("wait4", 16'h3A42, 4, 1'b0);
    // Abort a fetch mid-wait: the request must vanish as soon as clr rises.
    imem_valid = 1'b0;
    step();
    step();
    e = idle_exp(16'h3A42); e.imem_rd = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_pre: got %h expected %h", obs, e);
    end
    clr = 1'b1;
    #1;
    e = idle_exp(16'h0000); e.pc_clr = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_clr: got %h expected %h", obs, e);
    end
    step();
    clr = 1'b0;
    step();
    e = idle_exp(16'h0000); e.imem_rd = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_refetch: got %h expected %h", obs, e);
    end
    cur_ir = 16'h0000;
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_OP_HALT_EN
    sig_t e;
    imem_valid = 1'b1;
    imem_data  = 16'h7000;
    step();
    imem_valid = 1'b0;
    e = idle_exp(16'h7000); e.pc_up = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL illegal_decode: got %h expected %h", obs, e);
    end
    e = '0; e.ir = 16'h7000; e.halted = 1'b1;
    for (int k = 0; k < 6; k++) begin
      imem_valid = 1'($urandom);
      step();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal_halt%0d: got %h expected %h", k, obs, e);
      end
    end
    apply_reset();
    e = idle_exp(16'h0000); e.imem_rd = 1'b1;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL illegal_recover: got %h expected %h", obs, e);
    end
`else
    exec_instr("illegal_nop", 16'h7000, 0, 1'b1);
    exec_instr("illegal_nop_f", 16'hF5A5, 1, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [15:0] instr;
    int op;
    for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_OP_HALT_EN
      op = $urandom_range(0, 5);
`else
      op = $urandom_range(0, 15);
`endif
      instr = {4'(op), 12'($urandom)};
      exec_instr("random", instr, $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    cur_ir = 16'h0000;
    test_reset();
    test_ldc();
    test_add_sub();
    test_jmpz();
    test_wait_and_reset();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
